// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared widths and word types for the counter DDS core
package counter_pkg;
   localparam int PHASE_W = 8;
   localparam int DEPTH   = 256;
   localparam int WORD_W  = 32;
   localparam int OUT_W   = 20;
   localparam int MASK_W  = 4;

   typedef logic [PHASE_W-1:0] phase_t;
   typedef logic [WORD_W-1:0]  word_t;
endpackage

// File: rtl/sine_ram.sv
// rtl/sine_ram.sv - 256x32 1W/1R RAM with byte mask and registered read of the top word bits
module sine_ram
   import counter_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              csb0,
   input  logic              web0,
   input  logic [MASK_W-1:0] wmask0,
   input  phase_t            addr0,
   input  word_t             din0,
   input  logic              csb1,
   input  phase_t            addr1,
   output logic [OUT_W-1:0]  dout1
);

   word_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (!csb0 && !web0) begin
         for (int i = 0; i < MASK_W; i++) begin
            if (wmask0[i]) begin
               mem[addr0][8*i +: 8] <= din0[8*i +: 8];
            end
         end
      end
   end

   // Non-blocking update gives read-before-write on a same-edge address collision.
   always_ff @(posedge clk) begin
      if (reset) begin
         dout1 <= '0;
      end else if (!csb1) begin
         dout1 <= mem[addr1][WORD_W-1 -: OUT_W];
      end
   end

endmodule

// File: rtl/counter.sv
// rtl/counter.sv - phase accumulator with preload addressing a sine lookup RAM
module counter
   import counter_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              preload,
   input  logic              up_dn,
   input  logic [3:0]        delta,
   input  logic [7:0]        pl_data,
   output logic [7:0]        qout,
   output logic [19:0]       freq_out,
   input  logic              csb0,
   input  logic              web0,
   input  logic [3:0]        wmask0,
   input  logic [7:0]        addr0,
   input  logic [31:0]       din0,
   input  logic              csb1
);

   phase_t step;

   assign step = {4'b0000, delta};

   always_ff @(posedge clk) begin
      if (reset) begin
         qout <= '0;
      end else if (preload) begin
         qout <= pl_data;
      end else if (up_dn) begin
         qout <= qout + step;
      end else begin
         qout <= qout - step;
      end
   end

   sine_ram u_ram (
      .clk    (clk),
      .reset  (reset),
      .csb0   (csb0),
      .web0   (web0),
      .wmask0 (wmask0),
      .addr0  (addr0),
      .din0   (din0),
      .csb1   (csb1),
      .addr1  (qout),
      .dout1  (freq_out)
   );

endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - self-checking bench for the counter DDS core
module tb_counter;

   logic        clk = 1'b0;
   logic        reset, preload, up_dn, csb0, web0, csb1;
   logic [3:0]  delta, wmask0;
   logic [7:0]  pl_data, addr0, qout;
   logic [31:0] din0;
   logic [19:0] freq_out;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] sine [256];

   // reference model state
   int          m_q;
   logic [19:0] m_freq;
   bit          m_freq_known = 0;
   bit          model_on = 0;
   int          m_src = -1;
   logic [31:0] m_mem [256];
   bit          m_wr [256];
   bit          sine_on = 0;

   always #5 clk = ~clk;

   counter dut (
      .clk(clk), .reset(reset), .preload(preload), .up_dn(up_dn),
      .delta(delta), .pl_data(pl_data), .qout(qout), .freq_out(freq_out),
      .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
      .din0(din0), .csb1(csb1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      int old_q;
      old_q = m_q;
      if (reset) begin
         m_q = 0;
         m_freq = '0;
         m_freq_known = 1;
         m_src = -1;
         model_on = 1;
      end else begin
         if (preload) m_q = pl_data;
         else if (up_dn) m_q = (old_q + delta) % 256;
         else m_q = (old_q + 256 - delta) % 256;
         if (!csb1) begin
            m_freq = m_mem[old_q][31:12];
            m_freq_known = m_wr[old_q];
            m_src = old_q;
         end
      end
      if (!csb0 && !web0) begin
         for (int b = 0; b < 4; b++)
            if (wmask0[b]) m_mem[addr0][8*b +: 8] = din0[8*b +: 8];
         m_wr[addr0] = 1;
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         chk("qout_model", {24'h0, qout}, m_q);
         if (m_freq_known) chk("freq_model", {12'h0, freq_out}, {12'h0, m_freq});
         if (sine_on && m_src == 64) chk("sine_peak", {12'h0, freq_out}, 32'h7FFFF);
         if (sine_on && m_src == 192) chk("sine_trough", {12'h0, freq_out}, 32'h80000);
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
      csb0 = 0; web0 = 0; addr0 = a; din0 = d; wmask0 = m;
      tick();
      csb0 = 1; web0 = 1;
   endtask

   initial begin
      real r;
      longint v;
      for (int i = 0; i < 256; i++) begin
         r = $sin(3.14159265358979323846 * i / 128.0) * 2147483647.0;
         v = longint'(r);
         sine[i] = v[31:0];
         m_wr[i] = 0;
      end

      reset = 1; preload = 0; up_dn = 1; delta = 0; pl_data = 0;
      csb0 = 1; web0 = 1; wmask0 = 0; addr0 = 0; din0 = 0; csb1 = 1;

      // reset, then count up through the wrap
      repeat (3) tick();
      chk("reset_qout", {24'h0, qout}, 32'h0);
      chk("reset_freq", {12'h0, freq_out}, 32'h0);
      reset = 0; up_dn = 1; delta = 1;
      for (int i = 1; i <= 256; i++) begin
         tick();
         chk("count_up", {24'h0, qout}, i % 256);
      end

      // down count with wrap, then hold
      preload = 1; pl_data = 8'd1;
      tick();
      preload = 0; up_dn = 0; delta = 3;
      tick(); chk("down_wrap", {24'h0, qout}, 32'd254);
      tick(); chk("down_251", {24'h0, qout}, 32'd251);
      delta = 0;
      tick(); tick(); chk("delta0_hold", {24'h0, qout}, 32'd251);
      preload = 1; pl_data = 8'd254; up_dn = 1; delta = 3;
      tick();
      preload = 0;
      tick(); chk("up_wrap", {24'h0, qout}, 32'd1);

      // preload priority
      delta = 1;
      tick();
      preload = 1; pl_data = 8'h80;
      tick(); chk("preload", {24'h0, qout}, 32'h80);
      reset = 1;
      tick(); chk("reset_over_preload", {24'h0, qout}, 32'h0);
      reset = 0; preload = 0;
      tick(); chk("resume_after_reset", {24'h0, qout}, 32'd1);

      // masked write and read-back
      wr(8'h10, 32'h12345678, 4'hF);
      wr(8'h10, 32'h000000AA, 4'b0001);
      preload = 1; pl_data = 8'h10; delta = 0; csb1 = 0;
      tick();
      preload = 0;
      tick(); chk("masked_word", {12'h0, freq_out}, 32'h12345);
      csb1 = 1;

      // sine load and playback at several steps
      for (int i = 0; i < 256; i++) wr(i[7:0], sine[i], 4'hF);
      chk("sine_tbl_64", sine[64], 32'h7FFFFFFF);
      chk("sine_tbl_192", sine[192], 32'h80000001);
      preload = 1; pl_data = 0; up_dn = 1; delta = 1;
      tick();
      preload = 0; csb1 = 0; sine_on = 1;
      for (int d = 1; d <= 5; d++) begin
         delta = d[3:0];
         repeat (1000) tick();
      end
      sine_on = 0;

      // read disable freezes freq_out
      preload = 1; pl_data = 8'd64; delta = 0;
      tick();
      preload = 0;
      tick(); chk("peak_before_freeze", {12'h0, freq_out}, 32'h7FFFF);
      csb1 = 1; delta = 1;
      repeat (10) tick();
      chk("frozen_qout", {24'h0, qout}, 32'd74);
      chk("frozen_freq", {12'h0, freq_out}, 32'h7FFFF);

      // same-edge write and read of one address
      preload = 1; pl_data = 8'h20; delta = 0; csb1 = 0;
      tick();
      preload = 0;
      wr(8'h20, 32'hABCDE123, 4'hF);
      chk("rbw_old", {12'h0, freq_out}, {12'h0, sine[32][31:12]});
      tick(); chk("rbw_new", {12'h0, freq_out}, 32'hABCDE);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
